// File: rtl/iter_shifter_pkg.sv
// Shared encodings for the iterative shifter: operation codes and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/iter_shifter_if.sv
// Request/response bundle of the iterative shifter; master issues requests, slave is the shifter.
interface iter_shifter_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
);
  import shift_pkg::*;

  logic                start;
  op_t                 op;
  logic [SHAMT_W-1:0]  shamt;
  logic [DATA_W-1:0]   data_in;
  logic                busy;
  logic                done;
  logic [DATA_W-1:0]   result;
  logic                illegal_op;

  modport master (
    output start, op, shamt, data_in,
    input  busy, done, result, illegal_op
  );

  modport slave (
    input  start, op, shamt, data_in,
    output busy, done, result, illegal_op
  );

endinterface

// File: rtl/iter_shifter_step.sv
// One-bit shift/rotate step used by the iterative shifter datapath.
// ROR rotates only when ITER_SHIFTER_ROTATE_EN is defined; otherwise it passes the value through.
module shift_step
  import shift_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  op_t               op,
  input  logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] value_next
);

  always_comb begin
    value_next = value;
    case (op)
      OP_SLL: value_next = {value[DATA_W-2:0], 1'b0};
      OP_SRL: value_next = {1'b0, value[DATA_W-1:1]};
      OP_SRA: value_next = {value[DATA_W-1], value[DATA_W-1:1]};
`ifdef ITER_SHIFTER_ROTATE_EN
      OP_ROR: value_next = {value[0], value[DATA_W-1:1]};
`else
      OP_ROR: value_next = value;
`endif
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Iterative shifter: one bit per cycle through a single shift_step, IDLE -> SHIFT -> DONE.
// Build option ITER_SHIFTER_ROTATE_EN enables ROR; without it op=11 is rejected with illegal_op.
module iter_shifter
  import shift_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5   // must equal $clog2(DATA_W)
) (
  input  logic           clk,
  input  logic           reset,
  iter_shifter_if.slave  bus
);

  state_t              state;
  op_t                 op_q;
  logic [SHAMT_W-1:0]  count;
  logic [DATA_W-1:0]   result_q;
  logic [DATA_W-1:0]   step_val;
  logic                busy_q;
  logic                done_q;
  logic                illegal_q;
  logic                reject;

`ifdef ITER_SHIFTER_ROTATE_EN
  assign reject = 1'b0;
`else
  assign reject = (bus.op == OP_ROR);
`endif

  shift_step #(.DATA_W(DATA_W)) u_step (
    .op         (op_q),
    .value      (result_q),
    .value_next (step_val)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_SLL;
      count     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q     <= bus.op;
            result_q <= bus.data_in;
            busy_q   <= 1'b1;
            if (reject) begin
              // rejected op completes immediately with the operand untouched
              count     <= '0;
              state     <= DONE;
              done_q    <= 1'b1;
              illegal_q <= 1'b1;
            end else if (bus.shamt != '0) begin
              count <= bus.shamt;
              state <= SHIFT;
            end else begin
              count  <= '0;
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          result_q <= step_val;
          count    <= count - SHAMT_W'(1);
          if (count == SHAMT_W'(1)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed + random bench for iter_shifter with a scoreboard queue of expected completions.
module tb_iter_shifter;
  import shift_pkg::*;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
`ifdef ITER_SHIFTER_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];
  logic [31:0] last_res;

  iter_shifter_if #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) bus ();

  iter_shifter #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input op_t o, input int s, input logic [31:0] d);
    case (o)
      OP_SLL:  return d << s;
      OP_SRL:  return d >> s;
      OP_SRA:  return $unsigned($signed(d) >>> s);
      default: return ROT ? ((d >> s) | (d << (32 - s))) : d;
    endcase
  endfunction

  task automatic drive_junk();
    bus.op      = op_t'($urandom_range(0, 3));
    bus.shamt   = SHAMT_W'($urandom_range(0, 31));
    bus.data_in = $urandom;
  endtask

  // Issue one request; inject > 0 pulses a competing start after that many edges.
  task automatic run_op(input op_t o, input int sh, input logic [31:0] d,
                        input logic [31:0] er, input logic ei, input int el, input int inject);
    exp_t e;
    exp_t got;
    int   lat;
    int   busy_cnt;
    bit   seen;
    e.res = er; e.ill = ei; e.lat = el;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = o;
    bus.shamt   = SHAMT_W'(sh);
    bus.data_in = d;
    sb.push_back(e);
    lat = 0; busy_cnt = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy) busy_cnt++;
      if (bus.done) seen = 1'b1;
      if (i == 0) begin
        bus.start = 1'b0;
        drive_junk();
      end
      if (inject > 0 && lat == inject) begin
        bus.start   = 1'b1;
        bus.op      = OP_SRL;
        bus.shamt   = SHAMT_W'(1);
        bus.data_in = 32'h0000_1234;
      end else if (inject > 0 && lat == inject + 1) begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    if (!seen) begin
      chk("done_timeout", 32'(lat), 32'(el));
    end else if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk("result", bus.result, got.res);
      chk("illegal_op", 32'(bus.illegal_op), 32'(got.ill));
      chk("latency", 32'(lat), 32'(got.lat));
      chk("busy_cycles", 32'(busy_cnt), 32'(got.lat));
      last_res = bus.result;
    end
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("busy_after_done", 32'(bus.busy), 32'd0);
    chk("illegal_after_done", 32'(bus.illegal_op), 32'd0);
  endtask

  initial begin
    int dpulses;
    op_t ro;
    int  rs;
    logic [31:0] rd;
    checks = 0; errors = 0; last_res = '0;
    reset = 1'b1;
    bus.start = 1'b0;
    drive_junk();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_result", bus.result, 32'd0);
    chk("reset_illegal", 32'(bus.illegal_op), 32'd0);
    reset = 1'b0;

    run_op(OP_SLL, 4, 32'h0000_0001, 32'h0000_0010, 1'b0, 5, 0);
    run_op(OP_SRA, 31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32, 0);
    run_op(OP_SRL, 31, 32'h8000_0000, 32'h0000_0001, 1'b0, 32, 0);
    run_op(OP_SRL, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1, 0);
    run_op(OP_SLL, 8, 32'h0000_00FF, 32'h0000_FF00, 1'b0, 9, 2);

    // abort an in-flight shift: reset sampled at the edge ending the 3rd SHIFT cycle
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_SLL; bus.shamt = SHAMT_W'(10); bus.data_in = 32'h0000_0005;
    dpulses = 0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (bus.done) dpulses++;
      @(posedge clk); #1;
    end
    if (bus.done) dpulses++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_result", bus.result, 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done) dpulses++;
    end
    chk("abort_no_done_pulse", 32'(dpulses), 32'd0);
    run_op(OP_SLL, 1, 32'h0000_0003, 32'h0000_0006, 1'b0, 2, 0);

    if (ROT) run_op(OP_ROR, 4, 32'h0000_000F, 32'hF000_0000, 1'b0, 5, 0);
    else     run_op(OP_ROR, 4, 32'h0000_000F, 32'h0000_000F, 1'b1, 1, 0);

    for (int k = 0; k < 6; k++) begin
      ro = op_t'($urandom_range(0, 3));
      rs = $urandom_range(0, 31);
      rd = $urandom;
      if (ro == OP_ROR && !ROT) run_op(ro, rs, rd, rd, 1'b1, 1, 0);
      else                      run_op(ro, rs, rd, model(ro, rs, rd), 1'b0, rs + 1, 0);
    end

    // result must hold while idle with wandering inputs
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_junk();
    end
    #1;
    chk("result_hold", bus.result, last_res);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
